// File: rtl/filter_pkg.sv
// Shared definitions for the 5x5 filter line-buffer controller.
package filter_pkg;

  localparam int unsigned FILL_LINES   = 4;
  localparam int unsigned PIPE_LAT_DEF = 2;
  localparam int unsigned MIN_DIM      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // 4-bit one-hot of a 2-bit index; narrower users truncate
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'(1) << idx;
  endfunction

endpackage

// File: rtl/filter_line_cnt.sv
// Raster pixel/line counter with frame-size latching and position flags.
module filter_line_cnt
  import filter_pkg::*;
#(
  parameter int unsigned X_W = 11,
  parameter int unsigned L_W = 11
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           inc,
  input  logic [X_W-1:0] hsize,
  input  logic [L_W-1:0] vsize,
  output logic [X_W-1:0] x,
  output logic [L_W-1:0] line,
  output logic           at_sol_c,
  output logic           at_eol_c,
  output logic           at_last_c,
  output logic           small_c
);

  logic [X_W-1:0] hsize_q;
  logic [L_W-1:0] vsize_q;

  // start has priority so a restart discards any pixel in the same cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hsize_q <= '0;
      vsize_q <= '0;
      x       <= '0;
      line    <= '0;
    end else if (start) begin
      hsize_q <= hsize;
      vsize_q <= vsize;
      x       <= '0;
      line    <= '0;
    end else if (inc) begin
      if (at_eol_c) begin
        x    <= '0;
        line <= line + L_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

  assign at_sol_c  = (x == '0);
  assign at_eol_c  = (x == hsize_q - X_W'(1));
  assign at_last_c = at_eol_c && (line == vsize_q - L_W'(1));
  assign small_c   = (hsize_q < X_W'(MIN_DIM)) || (vsize_q < L_W'(MIN_DIM));

endmodule

// File: rtl/filter_line_buf_ctrl.sv
// Line-buffer sequencer for the 5x5 filter: bank enables, addresses and
// window-output framing aligned to the align-stage latency.
module filter_line_buf_ctrl
  import filter_pkg::*;
#(
  parameter int unsigned MEM_Y_WIDTH    = 4,
  parameter int unsigned MEM_U_WIDTH    = 2,
  parameter int unsigned MEM_V_WIDTH    = 2,
  parameter int unsigned MEM_ADDR_WIDTH = 11,
  parameter int unsigned V_WIDTH        = 11,
  parameter int unsigned PIPE_LAT       = PIPE_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_sof,
  input  logic                      i_valid,
  input  logic [MEM_ADDR_WIDTH-1:0] i_hsize,
  input  logic [V_WIDTH-1:0]        i_vsize,
  output logic [MEM_Y_WIDTH-1:0]    o_mem_y_wen,
  output logic [MEM_Y_WIDTH-1:0]    o_mem_y_ren,
  output logic [MEM_U_WIDTH-1:0]    o_mem_u_wen,
  output logic [MEM_V_WIDTH-1:0]    o_mem_v_wen,
  output logic [MEM_U_WIDTH-1:0]    o_mem_u_ren,
  output logic [MEM_V_WIDTH-1:0]    o_mem_v_ren,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_raddr,
  output logic [1:0]                o_old_bank,
  output logic                      o_valid,
  output logic                      o_sol,
  output logic                      o_eol,
  output logic                      o_eof,
  output logic                      o_busy
);

  state_t state, state_nxt;
  logic   eof_nxt;
  logic   acc, run_acc;
  logic   sol_c, eol_c, last_c, small_c;
  logic   v_in, s_in, e_in;
  logic [MEM_ADDR_WIDTH-1:0] x;
  logic [V_WIDTH-1:0]        line;
  logic [1:0]                line_m2;

  logic [PIPE_LAT-1:0] v_pipe, s_pipe, e_pipe;
  logic [1:0]          b_pipe [PIPE_LAT];

  filter_line_cnt #(
    .X_W(MEM_ADDR_WIDTH),
    .L_W(V_WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .start    (i_sof),
    .inc      (acc),
    .hsize    (i_hsize),
    .vsize    (i_vsize),
    .x        (x),
    .line     (line),
    .at_sol_c (sol_c),
    .at_eol_c (eol_c),
    .at_last_c(last_c),
    .small_c  (small_c)
  );

  assign acc     = i_valid && ((state == FILL) || (state == RUN));
  assign run_acc = acc && (state == RUN);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // a short frame can finish while still filling, so last-pixel wins over RUN entry
  always_comb begin
    state_nxt = state;
    eof_nxt   = 1'b0;
    case (state)
      IDLE: if (i_sof) state_nxt = FILL;
      FILL: begin
        if (i_sof) begin
          state_nxt = FILL;
        end else if (acc && last_c) begin
          state_nxt = DONE;
          eof_nxt   = 1'b1;
        end else if (acc && eol_c && (line == V_WIDTH'(FILL_LINES - 1))) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_sof) begin
          state_nxt = FILL;
        end else if (acc && last_c) begin
          state_nxt = DONE;
          eof_nxt   = 1'b1;
        end
      end
      DONE:    state_nxt = i_sof ? FILL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // chroma read bank is the one holding line-2, i.e. bit 1 of (line-2)
  assign line_m2 = line[1:0] - 2'd2;

  assign o_mem_y_wen = acc ? MEM_Y_WIDTH'(onehot(line[1:0])) : '0;
  assign o_mem_y_ren = run_acc ? '1 : '0;
  assign o_mem_u_wen = (acc && !line[0]) ? MEM_U_WIDTH'(onehot({1'b0, line[1]})) : '0;
  assign o_mem_v_wen = (acc && !line[0]) ? MEM_V_WIDTH'(onehot({1'b0, line[1]})) : '0;
  assign o_mem_u_ren = run_acc ? MEM_U_WIDTH'(onehot({1'b0, line_m2[1]})) : '0;
  assign o_mem_v_ren = run_acc ? MEM_V_WIDTH'(onehot({1'b0, line_m2[1]})) : '0;
  assign o_mem_waddr = x;
  assign o_mem_raddr = x;
  assign o_busy      = (state != IDLE);

  assign v_in = run_acc && !small_c;
  assign s_in = v_in && sol_c;
  assign e_in = v_in && eol_c;

  // output framing delayed to match RAM read plus align register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v_pipe <= '0;
      s_pipe <= '0;
      e_pipe <= '0;
      o_eof  <= 1'b0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) b_pipe[i] <= '0;
    end else begin
      v_pipe    <= {v_pipe[PIPE_LAT-2:0], v_in};
      s_pipe    <= {s_pipe[PIPE_LAT-2:0], s_in};
      e_pipe    <= {e_pipe[PIPE_LAT-2:0], e_in};
      o_eof     <= eof_nxt;
      b_pipe[0] <= line[1:0];
      for (int unsigned i = 1; i < PIPE_LAT; i++) b_pipe[i] <= b_pipe[i-1];
    end
  end

  assign o_valid    = v_pipe[PIPE_LAT-1];
  assign o_sol      = s_pipe[PIPE_LAT-1];
  assign o_eol      = e_pipe[PIPE_LAT-1];
  assign o_old_bank = b_pipe[PIPE_LAT-1];

endmodule
